// File: rtl/ysyx_bus_arb_if.sv
// IFU/LSU upstream and single-port downstream signal bundle
// for the ysyx bus arbiter.
interface ysyx_bus_arb_if #(
  parameter int XLEN = 32
);
  logic              ifu_arvalid;
  logic [XLEN-1:0]   ifu_araddr;
  logic              ifu_lock;
  logic              out_ifu_ready;
  logic [XLEN-1:0]   out_ifu_rdata;
  logic              out_ifu_rvalid;

  logic              lsu_arvalid;
  logic [XLEN-1:0]   lsu_araddr;
  logic              lsu_awvalid;
  logic [XLEN-1:0]   lsu_awaddr;
  logic [XLEN-1:0]   lsu_wdata;
  logic [XLEN/8-1:0] lsu_wstrb;
  logic              out_lsu_ready;
  logic [XLEN-1:0]   out_lsu_rdata;
  logic              out_lsu_rvalid;
  logic              out_lsu_bvalid;

  logic              out_arvalid;
  logic [XLEN-1:0]   out_araddr;
  logic              out_awvalid;
  logic [XLEN-1:0]   out_awaddr;
  logic [XLEN-1:0]   out_wdata;
  logic [XLEN/8-1:0] out_wstrb;
  logic              arready;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;
  logic              awready;
  logic              bvalid;

  modport master (
    input  ifu_arvalid, ifu_araddr, ifu_lock,
    output out_ifu_ready, out_ifu_rdata, out_ifu_rvalid,
    input  lsu_arvalid, lsu_araddr,
    input  lsu_awvalid, lsu_awaddr, lsu_wdata, lsu_wstrb,
    output out_lsu_ready, out_lsu_rdata,
    output out_lsu_rvalid, out_lsu_bvalid,
    output out_arvalid, out_araddr,
    output out_awvalid, out_awaddr, out_wdata, out_wstrb,
    input  arready, rvalid, rdata, awready, bvalid
  );

  modport slave (
    output ifu_arvalid, ifu_araddr, ifu_lock,
    input  out_ifu_ready, out_ifu_rdata, out_ifu_rvalid,
    output lsu_arvalid, lsu_araddr,
    output lsu_awvalid, lsu_awaddr, lsu_wdata, lsu_wstrb,
    input  out_lsu_ready, out_lsu_rdata,
    input  out_lsu_rvalid, out_lsu_bvalid,
    input  out_arvalid, out_araddr,
    input  out_awvalid, out_awaddr, out_wdata, out_wstrb,
    output arready, rvalid, rdata, awready, bvalid
  );
endinterface

// File: rtl/ysyx_bus_arb.sv
// Round-robin IFU/LSU arbiter onto one downstream bus,
// one outstanding transaction, with IFU burst lock.
module ysyx_bus_arb #(
  parameter int XLEN = 32
) (
  input  logic          clock,
  input  logic          reset,
  ysyx_bus_arb_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    IFU_AR,
    IFU_R,
    LSU_AR,
    LSU_R,
    LSU_AW,
    LSU_B
  } state_t;

  state_t            state_q, state_d;
  logic              last_lsu_q, last_lsu_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN/8-1:0] wstrb_q, wstrb_d;

  logic lsu_req;
  logic gnt_ifu;
  logic gnt_lsu_w;
  logic gnt_lsu_r;

  assign lsu_req   = bus.lsu_arvalid | bus.lsu_awvalid;
  assign gnt_ifu   = bus.ifu_arvalid
                   & (~lsu_req | last_lsu_q);
  assign gnt_lsu_w = ~gnt_ifu & bus.lsu_awvalid;
  assign gnt_lsu_r = ~gnt_ifu & ~bus.lsu_awvalid
                   & bus.lsu_arvalid;

  assign bus.out_araddr = addr_q;
  assign bus.out_awaddr = addr_q;
  assign bus.out_wdata  = wdata_q;
  assign bus.out_wstrb  = wstrb_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      last_lsu_q <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_lsu_q <= last_lsu_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    last_lsu_d         = last_lsu_q;
    addr_d             = addr_q;
    wdata_d            = wdata_q;
    wstrb_d            = wstrb_q;
    bus.out_ifu_ready  = 1'b0;
    bus.out_ifu_rdata  = '0;
    bus.out_ifu_rvalid = 1'b0;
    bus.out_lsu_ready  = 1'b0;
    bus.out_lsu_rdata  = '0;
    bus.out_lsu_rvalid = 1'b0;
    bus.out_lsu_bvalid = 1'b0;
    bus.out_arvalid    = 1'b0;
    bus.out_awvalid    = 1'b0;
    // Outputs stay quiet while reset is held.
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            gnt_ifu: begin
              bus.out_ifu_ready = 1'b1;
              addr_d  = bus.ifu_araddr;
              state_d = IFU_AR;
            end
            gnt_lsu_w: begin
              bus.out_lsu_ready = 1'b1;
              addr_d  = bus.lsu_awaddr;
              wdata_d = bus.lsu_wdata;
              wstrb_d = bus.lsu_wstrb;
              state_d = LSU_AW;
            end
            gnt_lsu_r: begin
              bus.out_lsu_ready = 1'b1;
              addr_d  = bus.lsu_araddr;
              state_d = LSU_AR;
            end
            default: state_d = IDLE;
          endcase
        end
        IFU_AR: begin
          bus.out_arvalid = 1'b1;
          if (bus.arready) state_d = IFU_R;
        end
        IFU_R: begin
          bus.out_ifu_rdata  = bus.rdata;
          bus.out_ifu_rvalid = bus.rvalid;
          if (bus.rvalid) begin
            last_lsu_d = 1'b0;
            // Locked burst re-grants the IFU without arbitration.
            if (bus.ifu_lock && bus.ifu_arvalid) begin
              bus.out_ifu_ready = 1'b1;
              addr_d  = bus.ifu_araddr;
              state_d = IFU_AR;
            end else begin
              state_d = IDLE;
            end
          end
        end
        LSU_AR: begin
          bus.out_arvalid = 1'b1;
          if (bus.arready) state_d = LSU_R;
        end
        LSU_R: begin
          bus.out_lsu_rdata  = bus.rdata;
          bus.out_lsu_rvalid = bus.rvalid;
          if (bus.rvalid) begin
            last_lsu_d = 1'b1;
            state_d    = IDLE;
          end
        end
        LSU_AW: begin
          bus.out_awvalid = 1'b1;
          if (bus.awready) state_d = LSU_B;
        end
        LSU_B: begin
          bus.out_lsu_bvalid = bus.bvalid;
          if (bus.bvalid) begin
            last_lsu_d = 1'b1;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_bus_arb.sv
// Directed-vector bench for ysyx_bus_arb: reset, single read,
// tie, lock burst, delayed write, dropped valid, mid-read reset.
module tb_ysyx_bus_arb;

  logic clock;
  logic reset;
  int   tests;
  int   fails;

  ysyx_bus_arb_if #(.XLEN(32)) bus ();

  ysyx_bus_arb #(.XLEN(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ifu_arvalid = 1'b0;
    bus.ifu_araddr  = '0;
    bus.ifu_lock    = 1'b0;
    bus.lsu_arvalid = 1'b0;
    bus.lsu_araddr  = '0;
    bus.lsu_awvalid = 1'b0;
    bus.lsu_awaddr  = '0;
    bus.lsu_wdata   = '0;
    bus.lsu_wstrb   = '0;
    bus.arready     = 1'b0;
    bus.rvalid      = 1'b0;
    bus.rdata       = '0;
    bus.awready     = 1'b0;
    bus.bvalid      = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ifu_arvalid = 1'b1;
    bus.lsu_arvalid = 1'b1;
    bus.arready = 1'b1;
    bus.rvalid = 1'b1;
    bus.bvalid = 1'b1;
    #3;
    tests++;
    if (bus.out_ifu_ready !== 1'b0 || bus.out_lsu_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_ready got %b%b exp 00",
               bus.out_ifu_ready, bus.out_lsu_ready);
    end
    tests++;
    if (bus.out_arvalid !== 1'b0 || bus.out_awvalid !== 1'b0) begin
      fails++;
      $display("FAIL rst_avalid got %b%b exp 00",
               bus.out_arvalid, bus.out_awvalid);
    end
    tests++;
    if (bus.out_ifu_rvalid !== 1'b0 || bus.out_lsu_rvalid !== 1'b0
        || bus.out_lsu_bvalid !== 1'b0) begin
      fails++;
      $display("FAIL rst_resp got %b%b%b exp 000", bus.out_ifu_rvalid,
               bus.out_lsu_rvalid, bus.out_lsu_bvalid);
    end
    tests++;
    if (bus.out_araddr !== 32'h0) begin
      fails++;
      $display("FAIL rst_addr got %h exp 0", bus.out_araddr);
    end
    clear_inputs();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_ifu_single();
    bus.ifu_arvalid = 1'b1;
    bus.ifu_araddr = 32'h8000_0000;
    #3;
    tests++;
    if (bus.out_ifu_ready !== 1'b1 || bus.out_lsu_ready !== 1'b0) begin
      fails++;
      $display("FAIL single_grant got %b%b exp 10",
               bus.out_ifu_ready, bus.out_lsu_ready);
    end
    tests++;
    if (bus.out_arvalid !== 1'b0) begin
      fails++;
      $display("FAIL single_c0_arvalid got %b exp 0", bus.out_arvalid);
    end
    cyc();
    bus.ifu_arvalid = 1'b0;
    bus.ifu_araddr = 32'h1234_5678;
    #3;
    tests++;
    if (bus.out_arvalid !== 1'b1 || bus.out_araddr !== 32'h8000_0000) begin
      fails++;
      $display("FAIL single_c1_ar got %b/%h exp 1/80000000",
               bus.out_arvalid, bus.out_araddr);
    end
    tests++;
    if (bus.out_ifu_ready !== 1'b0) begin
      fails++;
      $display("FAIL single_c1_ready got %b exp 0", bus.out_ifu_ready);
    end
    cyc();
    bus.arready = 1'b1;
    #3;
    tests++;
    if (bus.out_arvalid !== 1'b1 || bus.out_araddr !== 32'h8000_0000) begin
      fails++;
      $display("FAIL single_c2_ar got %b/%h exp 1/80000000",
               bus.out_arvalid, bus.out_araddr);
    end
    cyc();
    bus.arready = 1'b0;
    #3;
    tests++;
    if (bus.out_arvalid !== 1'b0 || bus.out_ifu_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL single_c3 got ar=%b rv=%b exp 0/0",
               bus.out_arvalid, bus.out_ifu_rvalid);
    end
    cyc();
    bus.rvalid = 1'b1;
    bus.rdata = 32'h0000_0013;
    #3;
    tests++;
    if (bus.out_ifu_rvalid !== 1'b1 || bus.out_ifu_rdata !== 32'h13) begin
      fails++;
      $display("FAIL single_c4_r got %b/%h exp 1/00000013",
               bus.out_ifu_rvalid, bus.out_ifu_rdata);
    end
    tests++;
    if (bus.out_lsu_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL single_c4_lsu_rv got %b exp 0", bus.out_lsu_rvalid);
    end
    cyc();
    bus.rvalid = 1'b0;
    bus.arready = 1'b1;
    #3;
    tests++;
    if (bus.out_arvalid !== 1'b0 || bus.out_ifu_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL single_c5_idle got ar=%b rv=%b exp 0/0",
               bus.out_arvalid, bus.out_ifu_rvalid);
    end
    cyc();
    bus.arready = 1'b0;
  endtask

  task automatic test_tie();
    do_reset();
    bus.ifu_arvalid = 1'b1;
    bus.ifu_araddr = 32'h8000_0100;
    bus.lsu_arvalid = 1'b1;
    bus.lsu_araddr = 32'h0200_0000;
    #3;
    tests++;
    if (bus.out_ifu_ready !== 1'b1 || bus.out_lsu_ready !== 1'b0) begin
      fails++;
      $display("FAIL tie_grant got %b%b exp 10",
               bus.out_ifu_ready, bus.out_lsu_ready);
    end
    cyc();
    bus.ifu_arvalid = 1'b0;
    bus.arready = 1'b1;
    #3;
    tests++;
    if (bus.out_araddr !== 32'h8000_0100 || bus.out_lsu_ready !== 1'b0) begin
      fails++;
      $display("FAIL tie_ifu_ar got %h/%b exp 80000100/0",
               bus.out_araddr, bus.out_lsu_ready);
    end
    cyc();
    bus.arready = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata = 32'hAAAA_0001;
    #3;
    tests++;
    if (bus.out_ifu_rvalid !== 1'b1 || bus.out_lsu_rvalid !== 1'b0
        || bus.out_lsu_ready !== 1'b0) begin
      fails++;
      $display("FAIL tie_ifu_r got %b%b%b exp 100", bus.out_ifu_rvalid,
               bus.out_lsu_rvalid, bus.out_lsu_ready);
    end
    cyc();
    bus.rvalid = 1'b0;
    #3;
    tests++;
    if (bus.out_lsu_ready !== 1'b1 || bus.out_ifu_ready !== 1'b0) begin
      fails++;
      $display("FAIL tie_lsu_grant got %b%b exp 10",
               bus.out_lsu_ready, bus.out_ifu_ready);
    end
    cyc();
    bus.lsu_arvalid = 1'b0;
    bus.arready = 1'b1;
    #3;
    tests++;
    if (bus.out_arvalid !== 1'b1 || bus.out_araddr !== 32'h0200_0000) begin
      fails++;
      $display("FAIL tie_lsu_ar got %b/%h exp 1/02000000",
               bus.out_arvalid, bus.out_araddr);
    end
    cyc();
    bus.arready = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata = 32'h5555_0002;
    #3;
    tests++;
    if (bus.out_lsu_rvalid !== 1'b1 || bus.out_lsu_rdata !== 32'h5555_0002
        || bus.out_ifu_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL tie_lsu_r got %b/%h/%b exp 1/55550002/0",
               bus.out_lsu_rvalid, bus.out_lsu_rdata, bus.out_ifu_rvalid);
    end
    cyc();
    bus.rvalid = 1'b0;
  endtask

  task automatic test_lock();
    logic [31:0] base;
    logic        exp_rdy;
    base = 32'h8000_1000;
    bus.ifu_arvalid = 1'b1;
    bus.ifu_lock = 1'b1;
    bus.ifu_araddr = base;
    bus.lsu_arvalid = 1'b1;
    bus.lsu_araddr = 32'h0300_0000;
    #3;
    tests++;
    if (bus.out_ifu_ready !== 1'b1 || bus.out_lsu_ready !== 1'b0) begin
      fails++;
      $display("FAIL lock_grant0 got %b%b exp 10",
               bus.out_ifu_ready, bus.out_lsu_ready);
    end
    cyc();
    for (int i = 0; i < 4; i++) begin
      bus.arready = 1'b1;
      #3;
      tests++;
      if (bus.out_arvalid !== 1'b1
          || bus.out_araddr !== base + 32'(4 * i)) begin
        fails++;
        $display("FAIL lock_ar%0d got %b/%h exp 1/%h", i,
                 bus.out_arvalid, bus.out_araddr, base + 32'(4 * i));
      end
      cyc();
      bus.arready = 1'b0;
      bus.rvalid = 1'b1;
      bus.rdata = 32'(i);
      exp_rdy = (i < 3);
      bus.ifu_lock = exp_rdy;
      bus.ifu_araddr = base + 32'(4 * (i + 1));
      #3;
      tests++;
      if (bus.out_ifu_rvalid !== 1'b1 || bus.out_ifu_ready !== exp_rdy
          || bus.out_lsu_ready !== 1'b0) begin
        fails++;
        $display("FAIL lock_r%0d got rv=%b rdy=%b lrdy=%b exp 1/%b/0", i,
                 bus.out_ifu_rvalid, bus.out_ifu_ready,
                 bus.out_lsu_ready, exp_rdy);
      end
      cyc();
      bus.rvalid = 1'b0;
    end
    #3;
    tests++;
    if (bus.out_lsu_ready !== 1'b1 || bus.out_ifu_ready !== 1'b0) begin
      fails++;
      $display("FAIL lock_release got lsu=%b ifu=%b exp 1/0",
               bus.out_lsu_ready, bus.out_ifu_ready);
    end
    cyc();
    bus.ifu_arvalid = 1'b0;
    bus.lsu_arvalid = 1'b0;
    bus.arready = 1'b1;
    #3;
    tests++;
    if (bus.out_araddr !== 32'h0300_0000) begin
      fails++;
      $display("FAIL lock_lsu_ar got %h exp 03000000", bus.out_araddr);
    end
    cyc();
    bus.arready = 1'b0;
    bus.rvalid = 1'b1;
    #3;
    tests++;
    if (bus.out_lsu_rvalid !== 1'b1) begin
      fails++;
      $display("FAIL lock_lsu_r got %b exp 1", bus.out_lsu_rvalid);
    end
    cyc();
    bus.rvalid = 1'b0;
  endtask

  task automatic test_write();
    bus.lsu_awvalid = 1'b1;
    bus.lsu_awaddr = 32'h0200_0004;
    bus.lsu_wdata = 32'hDEAD_BEEF;
    bus.lsu_wstrb = 4'hF;
    bus.lsu_arvalid = 1'b1;
    bus.lsu_araddr = 32'h0400_0000;
    #3;
    tests++;
    if (bus.out_lsu_ready !== 1'b1 || bus.out_ifu_ready !== 1'b0) begin
      fails++;
      $display("FAIL wr_grant got %b%b exp 10",
               bus.out_lsu_ready, bus.out_ifu_ready);
    end
    cyc();
    bus.lsu_awvalid = 1'b0;
    bus.lsu_arvalid = 1'b0;
    bus.lsu_wdata = 32'h0;
    bus.lsu_wstrb = 4'h0;
    for (int i = 0; i < 4; i++) begin
      bus.awready = (i == 3);
      #3;
      tests++;
      if (bus.out_awvalid !== 1'b1 || bus.out_arvalid !== 1'b0
          || bus.out_awaddr !== 32'h0200_0004
          || bus.out_wdata !== 32'hDEAD_BEEF || bus.out_wstrb !== 4'hF) begin
        fails++;
        $display("FAIL wr_aw%0d got %b%b %h %h %h exp 10 02000004 deadbeef f",
                 i, bus.out_awvalid, bus.out_arvalid, bus.out_awaddr,
                 bus.out_wdata, bus.out_wstrb);
      end
      cyc();
    end
    bus.awready = 1'b0;
    #3;
    tests++;
    if (bus.out_awvalid !== 1'b0 || bus.out_lsu_bvalid !== 1'b0) begin
      fails++;
      $display("FAIL wr_b_wait got %b%b exp 00",
               bus.out_awvalid, bus.out_lsu_bvalid);
    end
    cyc();
    bus.bvalid = 1'b1;
    #3;
    tests++;
    if (bus.out_lsu_bvalid !== 1'b1 || bus.out_ifu_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL wr_b got %b%b exp 10",
               bus.out_lsu_bvalid, bus.out_ifu_rvalid);
    end
    cyc();
    bus.bvalid = 1'b0;
  endtask

  task automatic test_drop();
    bus.ifu_arvalid = 1'b1;
    bus.ifu_araddr = 32'h8000_2000;
    bus.lsu_arvalid = 1'b1;
    bus.lsu_araddr = 32'h0500_0000;
    #3;
    tests++;
    if (bus.out_ifu_ready !== 1'b1 || bus.out_lsu_ready !== 1'b0) begin
      fails++;
      $display("FAIL drop_grant got %b%b exp 10",
               bus.out_ifu_ready, bus.out_lsu_ready);
    end
    cyc();
    bus.ifu_arvalid = 1'b0;
    #3;
    tests++;
    if (bus.out_arvalid !== 1'b1 || bus.out_lsu_ready !== 1'b0) begin
      fails++;
      $display("FAIL drop_ar got %b%b exp 10",
               bus.out_arvalid, bus.out_lsu_ready);
    end
    cyc();
    bus.arready = 1'b1;
    cyc();
    bus.arready = 1'b0;
    #3;
    tests++;
    if (bus.out_lsu_ready !== 1'b0 || bus.out_ifu_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL drop_wait got %b%b exp 00",
               bus.out_lsu_ready, bus.out_ifu_rvalid);
    end
    cyc();
    bus.rvalid = 1'b1;
    bus.rdata = 32'h0000_0093;
    #3;
    tests++;
    if (bus.out_ifu_rvalid !== 1'b1 || bus.out_ifu_rdata !== 32'h93
        || bus.out_lsu_ready !== 1'b0) begin
      fails++;
      $display("FAIL drop_r got %b/%h/%b exp 1/00000093/0",
               bus.out_ifu_rvalid, bus.out_ifu_rdata, bus.out_lsu_ready);
    end
    cyc();
    bus.rvalid = 1'b0;
    #3;
    tests++;
    if (bus.out_lsu_ready !== 1'b1) begin
      fails++;
      $display("FAIL drop_lsu_grant got %b exp 1", bus.out_lsu_ready);
    end
    cyc();
    bus.lsu_arvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.arready = 1'b1;
    #3;
    tests++;
    if (bus.out_arvalid !== 1'b1 || bus.out_araddr !== 32'h0500_0000) begin
      fails++;
      $display("FAIL mid_ar got %b/%h exp 1/05000000",
               bus.out_arvalid, bus.out_araddr);
    end
    cyc();
    bus.arready = 1'b0;
    reset = 1'b1;
    bus.rvalid = 1'b1;
    bus.rdata = 32'hBAD0_0000;
    #3;
    tests++;
    if (bus.out_lsu_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL mid_rst_rv got %b exp 0", bus.out_lsu_rvalid);
    end
    cyc();
    reset = 1'b0;
    bus.arready = 1'b1;
    #3;
    tests++;
    if (bus.out_lsu_rvalid !== 1'b0 || bus.out_lsu_rdata !== 32'h0
        || bus.out_arvalid !== 1'b0 || bus.out_araddr !== 32'h0) begin
      fails++;
      $display("FAIL mid_stale got rv=%b rd=%h ar=%b a=%h exp 0/0/0/0",
               bus.out_lsu_rvalid, bus.out_lsu_rdata,
               bus.out_arvalid, bus.out_araddr);
    end
    cyc();
    bus.rvalid = 1'b0;
    bus.arready = 1'b0;
    bus.lsu_arvalid = 1'b1;
    #3;
    tests++;
    if (bus.out_lsu_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_idle_grant got %b exp 1", bus.out_lsu_ready);
    end
    cyc();
    clear_inputs();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clear_inputs();
    reset = 1'b1;
    cyc();
    test_reset();
    test_ifu_single();
    test_tie();
    test_lock();
    test_write();
    test_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_bus_arb.md
YSYX_BUS_ARB -- requirements
Module: ysyx_bus_arb

Interface
REQ-001 SHALL have parameter XLEN, default 32, the address and data width.
REQ-002 SHALL have port clock  in  1  system clock.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports ifu_arvalid  in  1  and ifu_araddr  in  XLEN: IFU read request and its address.
REQ-005 SHALL have port ifu_lock  in  1  IFU burst lock; keeps the bus for consecutive IFU reads.
REQ-006 SHALL have ports out_ifu_ready  out  1, out_ifu_rdata  out  XLEN and out_ifu_rvalid  out  1: IFU accept pulse, read data and read-data valid.
REQ-007 SHALL have ports lsu_arvalid  in  1  and lsu_araddr  in  XLEN: LSU read request and its address.
REQ-008 SHALL have ports lsu_awvalid  in  1, lsu_awaddr  in  XLEN, lsu_wdata  in  XLEN and lsu_wstrb  in  XLEN/8: LSU write request, address, data and byte strobes.
REQ-009 SHALL have ports out_lsu_ready  out  1, out_lsu_rdata  out  XLEN, out_lsu_rvalid  out  1 and out_lsu_bvalid  out  1: LSU accept pulse, read data, read-data valid and write-response valid.
REQ-010 SHALL have downstream outputs out_arvalid  1, out_araddr  XLEN, out_awvalid  1, out_awaddr  XLEN, out_wdata  XLEN and out_wstrb  XLEN/8.
REQ-011 SHALL have downstream inputs arready  1, rvalid  1, rdata  XLEN, awready  1 and bvalid  1.

Function
REQ-012 SHALL implement the states IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R, LSU_AW and LSU_B.
REQ-013 In IDLE, requesters SHALL be arbitrated round-robin using a last-grant bit: the requester not granted last wins a tie; with a single requester, that requester wins.
REQ-014 An LSU write SHALL take priority over an LSU read when both are asserted together.
REQ-015 The grant cycle SHALL pulse out_ifu_ready or out_lsu_ready for exactly 1 cycle.
REQ-016 On the grant cycle, the address, wdata and wstrb SHALL be latched into internal registers and the FSM SHALL move to IFU_AR, LSU_AR or LSU_AW.
REQ-017 In the *_AR and LSU_AW states, out_arvalid or out_awvalid SHALL be held high, driven from the latched registers, until the cycle arready or awready is high.
REQ-018 After the address handshake, the FSM SHALL enter the *_R or LSU_B state.
REQ-019 In IFU_R and LSU_R, rdata SHALL be forwarded combinationally to the owner, and out_*_rvalid SHALL equal rvalid.
REQ-020 In LSU_B, out_lsu_bvalid SHALL equal bvalid.
REQ-021 The non-owner's rvalid and bvalid outputs SHALL be 0 at all times.
REQ-022 Completion (rvalid in an *_R state, bvalid in LSU_B) SHALL return the FSM to IDLE and update the last-grant bit.
REQ-023 Lock: on IFU completion, if ifu_lock=1 and ifu_arvalid=1, the arbiter SHALL pulse out_ifu_ready, latch the new address and go directly to IFU_AR with no arbitration, even if the LSU is pending.
REQ-024 Lock released (ifu_lock=0 at completion): the arbiter SHALL return to IDLE, and a pending LSU SHALL win next.
REQ-025 A requester dropping its valid after grant SHALL NOT abort the transaction; the arbiter SHALL drain the response before leaving the state.
REQ-026 Minimum latency SHALL be: request at cycle 0, ready pulse at cycle 0, out_*valid at cycle 1, response forwarded in the same cycle as rvalid or bvalid.
REQ-027 The arbiter SHALL hold no more than one outstanding downstream transaction.
REQ-028 arready, rvalid, awready and bvalid arriving in a state that does not expect them SHALL be ignored.

Reset
REQ-029 Reset SHALL force state IDLE, last-grant to LSU (the IFU wins the first tie), and clear all latched registers.
REQ-030 During and after reset, all valid and ready outputs SHALL be 0 until the first grant.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction with no response forwarded.

Verification
REQ-032 Only IFU requests 0x8000_0000; arready at cycle 2; rvalid with rdata 0x00000013 at cycle 4 -> out_ifu_ready pulses at cycle 0, out_araddr=0x8000_0000 in cycles 1-2, out_ifu_rvalid=1 and out_ifu_rdata=0x13 at cycle 4, then IDLE.
REQ-033 IFU and LSU read arrive together right after reset -> IFU is granted first; after IFU completes, the LSU is granted at the next IDLE cycle.
REQ-034 IFU holds ifu_lock=1 for 4 reads while lsu_arvalid=1 throughout -> 4 back-to-back IFU grants with no LSU grant; the LSU is granted right after lock drops.
REQ-035 LSU write 0x0200_0004, wdata 0xDEADBEEF, wstrb 0xF; awready delayed 3 cycles -> out_awvalid is held stable for 3 cycles, and out_lsu_bvalid mirrors bvalid.
REQ-036 IFU drops ifu_arvalid one cycle after its grant -> the arbiter still completes the read and only then grants the LSU.
REQ-037 Reset is pulsed while in LSU_R -> state is IDLE, and no out_lsu_rvalid appears when a stale rvalid arrives.
